// File: rtl/serial_rx.sv
// Serial frame receiver: finds a 16'h5A5A header, deserializes 32-bit words,
// and writes them with a last-word flag to the FIFO write port.
module serial_rx #(
  parameter int DSIZE     = 32,
  parameter int MAX_WORDS = 256
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             s_in,
  input  logic             wfull,
  input  logic             err_clr,
  output logic [DSIZE:0]   wdata,
  output logic             winc,
  output logic             frame_done,
  output logic             err_ovf,
  output logic             err_frame
);

  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam logic [15:0] HEADER  = 16'h5A5A;
  localparam logic [15:0] TRAILER = 16'h0F0F;

  typedef enum logic [1:0] {HUNT, HI, LO} state_t;

  state_t           state_q, state_d;
  logic [15:0]      sh_q, sh_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      hi_q, hi_d;
  logic [DSIZE-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic [DSIZE:0]   wdata_q, wdata_d;
  logic             winc_q, winc_d;
  logic             frame_done_q, frame_done_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_frame_q, err_frame_d;

  logic [15:0]      hw;
  logic             wr_req;
  logic             wr_last;

  always_comb begin
    hw           = {s_in, sh_q[15:1]};
    sh_d         = hw;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q + 4'd1;
    hi_d         = hi_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    word_cnt_d   = word_cnt_q;
    wdata_d      = wdata_q;
    winc_d       = 1'b0;
    frame_done_d = 1'b0;
    err_ovf_d    = err_ovf_q & ~err_clr;
    err_frame_d  = err_frame_q & ~err_clr;
    wr_req       = 1'b0;
    wr_last      = 1'b0;

    unique case (state_q)
      HUNT: begin
        bit_cnt_d = 4'd0;
        if (hw == HEADER) begin
          state_d      = HI;
          pend_valid_d = 1'b0;
          word_cnt_d   = '0;
        end
      end
      HI: begin
        if (bit_cnt_q == 4'd15) begin
          if (hw == TRAILER) begin
            state_d      = HUNT;
            pend_valid_d = 1'b0;
            if (pend_valid_q) begin
              wr_req       = 1'b1;
              wr_last      = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              err_frame_d = 1'b1;
            end
          end else begin
            hi_d    = hw;
            state_d = LO;
          end
        end
      end
      LO: begin
        if (bit_cnt_q == 4'd15) begin
          // The held word is known not to be last here; only the new word is
          // discarded when the frame runs past MAX_WORDS.
          wr_req = pend_valid_q;
          if (word_cnt_q >= WCW'(MAX_WORDS)) begin
            err_frame_d  = 1'b1;
            pend_valid_d = 1'b0;
            state_d      = HUNT;
          end else begin
            pend_d       = {hi_q, hw};
            pend_valid_d = 1'b1;
            word_cnt_d   = word_cnt_q + WCW'(1);
            state_d      = HI;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (wr_req) begin
      if (wfull) begin
        err_ovf_d = 1'b1;
      end else begin
        winc_d  = 1'b1;
        wdata_d = {wr_last, pend_q};
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q      <= HUNT;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      hi_q         <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      word_cnt_q   <= '0;
      wdata_q      <= '0;
      winc_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      hi_q         <= hi_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      word_cnt_q   <= word_cnt_d;
      wdata_q      <= wdata_d;
      winc_q       <= winc_d;
      frame_done_q <= frame_done_d;
      err_ovf_q    <= err_ovf_d;
      err_frame_q  <= err_frame_d;
    end
  end

  assign wdata      = wdata_q;
  assign winc       = winc_q;
  assign frame_done = frame_done_q;
  assign err_ovf    = err_ovf_q;
  assign err_frame  = err_frame_q;

endmodule

// File: tb/tb_serial_rx.sv
// Directed self-checking bench for serial_rx: a default instance plus a
// MAX_WORDS=2 instance sharing the same line, checked against hand-computed writes.
module tb_serial_rx;

  logic        clk;
  logic        wrst;
  logic        s_in;
  logic        wfull;
  logic        err_clr;
  logic [32:0] wdata1, wdata2;
  logic        winc1, winc2;
  logic        done1, done2;
  logic        ovf1, ovf2;
  logic        ferr1, ferr2;

  int tests;
  int failures;
  int cyc;
  int done_cnt1;
  int hdr_cyc;

  logic [33:0] q1[$];
  logic [33:0] q2[$];
  int          wcyc1[$];

  serial_rx dut1 (
    .wclk(clk), .wrst(wrst), .s_in(s_in), .wfull(wfull), .err_clr(err_clr),
    .wdata(wdata1), .winc(winc1), .frame_done(done1),
    .err_ovf(ovf1), .err_frame(ferr1)
  );

  serial_rx #(.MAX_WORDS(2)) dut2 (
    .wclk(clk), .wrst(wrst), .s_in(s_in), .wfull(wfull), .err_clr(err_clr),
    .wdata(wdata2), .winc(winc2), .frame_done(done2),
    .err_ovf(ovf2), .err_frame(ferr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Each recorded write carries the frame_done value seen alongside it.
  always @(negedge clk) begin
    if (winc1) begin
      q1.push_back({done1, wdata1});
      wcyc1.push_back(cyc);
    end
    if (winc2) q2.push_back({done2, wdata2});
    if (done1) done_cnt1 = done_cnt1 + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests = tests + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [33:0] entry1(input int i);
    if (i < q1.size()) return q1[i];
    return '1;
  endfunction

  function automatic logic [33:0] entry2(input int i);
    if (i < q2.size()) return q2[i];
    return '1;
  endfunction

  task automatic sendBit(input logic b);
    s_in = b;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] hw);
    for (int i = 0; i < 16; i++) sendBit(hw[i]);
  endtask

  task automatic sendWord(input logic [31:0] w);
    applyStimulus(w[31:16]);
    applyStimulus(w[15:0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sendBit(1'b0);
  endtask

  task automatic clearLog();
    q1.delete();
    q2.delete();
    wcyc1.delete();
    done_cnt1 = 0;
  endtask

  task automatic resetDut();
    wrst = 1'b1;
    idle(2);
    wrst = 1'b0;
    idle(4);
  endtask

  initial begin
    tests     = 0;
    failures  = 0;
    cyc       = 0;
    done_cnt1 = 0;
    hdr_cyc   = 0;
    s_in      = 1'b0;
    wrst      = 1'b1;
    wfull     = 1'b0;
    err_clr   = 1'b0;
    @(negedge clk);

    // Reset with random line activity
    for (int i = 0; i < 2; i++) begin
      s_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checkOutput("rst_wdata", 64'(wdata1), 64'h0);
    checkOutput("rst_winc", 64'(winc1), 64'h0);
    checkOutput("rst_done", 64'(done1), 64'h0);
    checkOutput("rst_ovf", 64'(ovf1), 64'h0);
    checkOutput("rst_ferr", 64'(ferr1), 64'h0);
    wrst = 1'b0;
    idle(20);

    // Single word frame and its latency
    clearLog();
    applyStimulus(16'h5A5A);
    hdr_cyc = cyc;
    sendWord(32'hDEADBEEF);
    applyStimulus(16'h0F0F);
    idle(10);
    checkOutput("single_cnt", 64'(q1.size()), 64'd1);
    checkOutput("single_data", 64'(entry1(0)), {30'd0, 2'b11, 32'hDEADBEEF});
    checkOutput("single_lat", 64'(wcyc1.size() > 0 ? wcyc1[0] - hdr_cyc : -1), 64'd48);
    checkOutput("single_done_cnt", 64'(done_cnt1), 64'd1);
    checkOutput("single_ferr", 64'(ferr1), 64'h0);

    // Three words, order and last flag
    clearLog();
    applyStimulus(16'h5A5A);
    sendWord(32'h00000001);
    sendWord(32'h00000002);
    sendWord(32'h00000003);
    applyStimulus(16'h0F0F);
    idle(10);
    checkOutput("three_cnt", 64'(q1.size()), 64'd3);
    checkOutput("three_w0", 64'(entry1(0)), {30'd0, 2'b00, 32'h00000001});
    checkOutput("three_w1", 64'(entry1(1)), {30'd0, 2'b00, 32'h00000002});
    checkOutput("three_w2", 64'(entry1(2)), {30'd0, 2'b11, 32'h00000003});
    checkOutput("three_done_cnt", 64'(done_cnt1), 64'd1);

    // wfull during the second word's write decision
    clearLog();
    applyStimulus(16'h5A5A);
    sendWord(32'h11111111);
    sendWord(32'h22222222);
    applyStimulus(16'h3333);
    for (int i = 0; i < 15; i++) sendBit(1'b1 & (16'h3333 >> i));
    wfull = 1'b1;
    sendBit(1'b0);
    wfull = 1'b0;
    applyStimulus(16'h0F0F);
    idle(10);
    checkOutput("full_cnt", 64'(q1.size()), 64'd2);
    checkOutput("full_w0", 64'(entry1(0)), {30'd0, 2'b00, 32'h11111111});
    checkOutput("full_w1", 64'(entry1(1)), {30'd0, 2'b11, 32'h33333333});
    checkOutput("full_ovf_set", 64'(ovf1), 64'h1);
    err_clr = 1'b1;
    sendBit(1'b0);
    err_clr = 1'b0;
    idle(2);
    checkOutput("full_ovf_clr", 64'(ovf1), 64'h0);

    // Empty frame
    clearLog();
    applyStimulus(16'h5A5A);
    applyStimulus(16'h0F0F);
    idle(10);
    checkOutput("empty_cnt", 64'(q1.size()), 64'd0);
    checkOutput("empty_ferr", 64'(ferr1), 64'h1);
    checkOutput("empty_done", 64'(done_cnt1), 64'd0);

    // Too many words for the MAX_WORDS=2 instance
    resetDut();
    clearLog();
    applyStimulus(16'h5A5A);
    sendWord(32'h00000001);
    sendWord(32'h00000002);
    sendWord(32'h00000003);
    applyStimulus(16'h0F0F);
    idle(10);
    checkOutput("max_cnt", 64'(q2.size()), 64'd2);
    checkOutput("max_w0", 64'(entry2(0)), {30'd0, 2'b00, 32'h00000001});
    checkOutput("max_w1", 64'(entry2(1)), {30'd0, 2'b00, 32'h00000002});
    checkOutput("max_ferr", 64'(ferr2), 64'h1);
    checkOutput("max_dflt_ferr", 64'(ferr1), 64'h0);

    // Misaligned header after junk bits
    clearLog();
    sendBit(1'b1); sendBit(1'b1); sendBit(1'b0); sendBit(1'b0); sendBit(1'b1);
    applyStimulus(16'h5A5A);
    sendWord(32'h12345678);
    applyStimulus(16'h0F0F);
    idle(10);
    checkOutput("misalign_cnt", 64'(q1.size()), 64'd1);
    checkOutput("misalign_data", 64'(entry1(0)), {30'd0, 2'b11, 32'h12345678});

    // Reset mid-word, then a clean frame
    clearLog();
    applyStimulus(16'h5A5A);
    applyStimulus(16'hAAAA);
    for (int i = 0; i < 7; i++) sendBit(1'b1);
    wrst = 1'b1;
    sendBit(1'b0);
    wrst = 1'b0;
    idle(20);
    applyStimulus(16'h5A5A);
    sendWord(32'hCAFEF00D);
    applyStimulus(16'h0F0F);
    idle(10);
    checkOutput("midrst_cnt", 64'(q1.size()), 64'd1);
    checkOutput("midrst_data", 64'(entry1(0)), {30'd0, 2'b11, 32'hCAFEF00D});
    checkOutput("midrst_done", 64'(done_cnt1), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
